aes128_cbc_ctrl: RTL and testbench

AES128_CBC_CTRL -- requirements
Module: aes128_cbc_ctrl

---
 rtl/aes128_type_pkg.sv | 54 +++++
 rtl/aes128_cbc_ctrl_if.sv | 51 +++++
 rtl/aes128_word_bank.sv | 50 +++++
 rtl/aes128_cbc_ctrl.sv | 118 +++++++++++
 tb/tb_aes128_cbc_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes128_type_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_type_pkg
//  Description : Shared types and constants for the AES-128 CBC controller:
//                controller state encoding, chain mode, core operation code,
//                host word-address map and a word-insert helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package aes128_type_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_ARM       = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FINISH    = 3'd4
  } ctrl_state_e;

  // Block chaining mode
  typedef enum logic {
    CHAIN_ECB = 1'b0,
    CHAIN_CBC = 1'b1
  } chain_mode_e;

  // Operation code presented to the AES core
  typedef enum logic [1:0] {
    AES_ENC = 2'b00,
    AES_DEC = 2'b01
  } aes_op_e;

  // Host word-address map; each group is four 32-bit words
  localparam logic [3:0] KEY_BASE  = 4'd0;
  localparam logic [3:0] IV_BASE   = 4'd4;
  localparam logic [3:0] DATA_BASE = 4'd8;

  // Replace word idx of a 128-bit block; word 0 is the most significant.
  function automatic logic [127:0] put_word(input logic [127:0] blk,
                                            input logic [1:0]   idx,
                                            input logic [31:0]  word);
    logic [127:0] res;
    res = blk;
    case (idx)
      2'd0:    res[127:96] = word;
      2'd1:    res[95:64]  = word;
      2'd2:    res[63:32]  = word;
      default: res[31:0]   = word;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes128_cbc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_cbc_ctrl_if
//  Description : Host-side and core-side signal bundle of the AES-128 CBC
//                controller. Member names keep the controller's own port
//                names (_i = into the controller, _o = out of it).
//  Modports    : slave  - the controller
//                master - host plus AES core (testbench side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes128_cbc_ctrl_if;
  import aes128_type_pkg::*;

  // Host register writes and command
  logic          wr_en_i;
  logic [3:0]    wr_addr_i;
  logic [31:0]   wr_data_i;
  logic          go_i;
  logic          dec_i;
  logic          chain_i;
  // AES core handshake
  logic          core_start_o;
  aes_op_e       core_op_o;
  logic [127:0]  core_key_o;
  logic [127:0]  core_data_o;
  logic [127:0]  core_result_i;
  logic          core_valid_i;
  logic          core_ready_i;
  // Result and status
  logic [127:0]  out_data_o;
  logic          out_valid_o;
  logic          done_o;
  logic          busy_o;
  logic          err_o;

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, go_i, dec_i, chain_i,
    input  core_result_i, core_valid_i, core_ready_i,
    output core_start_o, core_op_o, core_key_o, core_data_o,
    output out_data_o, out_valid_o, done_o, busy_o, err_o
  );

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, go_i, dec_i, chain_i,
    output core_result_i, core_valid_i, core_ready_i,
    input  core_start_o, core_op_o, core_key_o, core_data_o,
    input  out_data_o, out_valid_o, done_o, busy_o, err_o
  );

endinterface
`default_nettype wire

// File: rtl/aes128_word_bank.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_word_bank
//  Description : Key, chain (IV) and data registers with host word-write
//                decode and the end-of-block chain update.
//  Ports       : clk, rst           - clock, async active-high reset
//                wr_en/addr/data    - qualified host word write
//                chain_upd          - load chain at block completion
//                chain_from_data    - chain source: data reg (1) / result (0)
//                result             - block returned by the AES core
//                key, chain, data   - register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module aes128_word_bank
  import aes128_type_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [3:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         chain_upd,
  input  logic         chain_from_data,
  input  logic [127:0] result,
  output logic [127:0] key,
  output logic [127:0] chain,
  output logic [127:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key   <= '0;
      chain <= '0;
      data  <= '0;
    end else if (chain_upd) begin
      // Host writes are only qualified in IDLE, so they never collide here.
      chain <= chain_from_data ? data : result;
    end else if (wr_en) begin
      if (wr_addr[3:2] == KEY_BASE[3:2]) begin
        key <= put_word(key, wr_addr[1:0], wr_data);
      end else if (wr_addr[3:2] == IV_BASE[3:2]) begin
        chain <= put_word(chain, wr_addr[1:0], wr_data);
      end else if (wr_addr[3:2] == DATA_BASE[3:2]) begin
        data <= put_word(data, wr_addr[1:0], wr_data);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes128_cbc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_cbc_ctrl
//  Description : Sequences one AES-128 block through an external core, adding
//                CBC chaining (pre-XOR on encrypt, post-XOR on decrypt).
//  Parameters  : CBC_EN - 1 builds chaining, 0 gives pure ECB
//  Ports       : clk_i  - clock, rising edge
//                rst_i  - asynchronous active-high reset
//                bus    - host writes/command, core handshake, result/status
//  Revision    : 1.0 - initial release
// ============================================================================
module aes128_cbc_ctrl
  import aes128_type_pkg::*;
#(
  parameter int CBC_EN = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  aes128_cbc_ctrl_if.slave bus
);

  ctrl_state_e  state, state_nxt;
  aes_op_e      op_mode;
  chain_mode_e  chain_mode, chain_req;
  logic [127:0] key, chain, data;
  logic [127:0] out_data;
  logic         out_valid, done, err;
  logic         idle, in_finish, cbc_enc, cbc_dec;
  logic         bank_wr, chain_upd;

  generate
    if (CBC_EN != 0) begin : g_cbc
      assign chain_req = chain_mode_e'(bus.chain_i);
    end else begin : g_ecb
      assign chain_req = CHAIN_ECB;
    end
  endgenerate

  assign idle      = (state == ST_IDLE);
  assign in_finish = (state == ST_FINISH);
  assign cbc_enc   = (chain_mode == CHAIN_CBC) && (op_mode == AES_ENC);
  assign cbc_dec   = (chain_mode == CHAIN_CBC) && (op_mode == AES_DEC);
  // Operands are frozen outside IDLE; a write in the go cycle still lands.
  assign bank_wr   = bus.wr_en_i && idle;
  assign chain_upd = in_finish && (chain_mode == CHAIN_CBC);

  aes128_word_bank u_bank (
    .clk             (clk_i),
    .rst             (rst_i),
    .wr_en           (bank_wr),
    .wr_addr         (bus.wr_addr_i),
    .wr_data         (bus.wr_data_i),
    .chain_upd       (chain_upd),
    .chain_from_data (op_mode == AES_DEC),
    .result          (bus.core_result_i),
    .key             (key),
    .chain           (chain),
    .data            (data)
  );

  // ARM spends one cycle after the start edge so the sticky valid left over
  // from the previous block has cleared before WAIT_DONE looks at it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (bus.go_i) state_nxt = ST_ISSUE;
      ST_ISSUE:     if (bus.core_ready_i) state_nxt = ST_ARM;
      ST_ARM:       state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.core_valid_i) state_nxt = ST_FINISH;
      ST_FINISH:    state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      op_mode    <= AES_ENC;
      chain_mode <= CHAIN_ECB;
      out_data   <= '0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (bus.go_i) begin
        if (idle) begin
          op_mode    <= bus.dec_i ? AES_DEC : AES_ENC;
          chain_mode <= chain_req;
          out_valid  <= 1'b0;
          err        <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
      if (in_finish) begin
        out_data  <= cbc_dec ? (bus.core_result_i ^ chain) : bus.core_result_i;
        out_valid <= 1'b1;
        done      <= 1'b1;
      end
    end
  end

  // Data and chain cannot change between go and FINISH, so the core operand
  // is derived directly from the registers and the latched mode.
  assign bus.core_data_o  = cbc_enc ? (data ^ chain) : data;
  assign bus.core_key_o   = key;
  assign bus.core_op_o    = op_mode;
  assign bus.core_start_o = (state == ST_ISSUE) && bus.core_ready_i;
  assign bus.out_data_o   = out_data;
  assign bus.out_valid_o  = out_valid;
  assign bus.done_o       = done;
  assign bus.busy_o       = !idle;
  assign bus.err_o        = err;

endmodule
`default_nettype wire

// File: tb/tb_aes128_cbc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes128_cbc_ctrl
//  Description : Self-checking bench for aes128_cbc_ctrl. A table-driven AES
//                core model answers known FIPS-197 / SP800-38A vectors; the
//                expected outputs are queued at each go and compared when
//                done_o appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes128_cbc_ctrl;
  import aes128_type_pkg::*;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV       = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1       = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C1       = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P2       = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C2       = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] ZERO     = 128'd0;
  localparam logic [127:0] ONE      = 128'd1;
  localparam int           CORE_LAT = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready_hold = 1'b0;
  always #5 clk = ~clk;

  aes128_cbc_ctrl_if bus();

  aes128_cbc_ctrl #(.CBC_EN(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int cm_starts = 0;
  int op_s0, op_d0;
  logic [127:0] sb[$];
  logic [127:0] mon_exp;

  // Known-answer table: tk/tp/tc = key / core input plaintext / ciphertext
  logic [127:0] tk[3], tp[3], tc[3];

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] aes_lookup(input logic [127:0] k,
                                              input logic [127:0] d,
                                              input logic dec);
    for (int i = 0; i < 3; i++) begin
      if (tk[i] == k && !dec && tp[i] == d) return tc[i];
      if (tk[i] == k &&  dec && tc[i] == d) return tp[i];
    end
    return ~d;
  endfunction

  // AES core model: sticky valid, cleared at the start edge
  int           cm_cnt;
  logic [127:0] cm_key, cm_data;
  logic         cm_dec;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cm_cnt            <= 0;
      bus.core_valid_i  <= 1'b0;
      bus.core_result_i <= '0;
    end else if (bus.core_start_o) begin
      cm_starts        <= cm_starts + 1;
      cm_key           <= bus.core_key_o;
      cm_data          <= bus.core_data_o;
      cm_dec           <= (bus.core_op_o == AES_DEC);
      cm_cnt           <= CORE_LAT;
      bus.core_valid_i <= 1'b0;
    end else if (cm_cnt != 0) begin
      cm_cnt <= cm_cnt - 1;
      if (cm_cnt == 1) begin
        bus.core_valid_i  <= 1'b1;
        bus.core_result_i <= aes_lookup(cm_key, cm_data, cm_dec);
      end
    end
  end
  assign bus.core_ready_i = (cm_cnt == 0) && !ready_hold;

  // Scoreboard consumer
  always @(negedge clk) begin
    if (bus.done_o === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 128'(bus.done_o), ZERO);
      end else begin
        mon_exp = sb.pop_front();
        check("out_data", bus.out_data_o, mon_exp);
        check("out_valid_at_done", 128'(bus.out_valid_o), ONE);
      end
    end
  end

  task automatic wr_word(input logic [3:0] a, input logic [31:0] d);
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = a;
    bus.wr_data_i = d;
    @(negedge clk);
    bus.wr_en_i   = 1'b0;
  endtask

  task automatic write_block(input logic [3:0] base, input logic [127:0] v,
                             input int nwords);
    logic [31:0] w;
    for (int n = 0; n < nwords; n++) begin
      w = v[127-32*n -: 32];
      wr_word(base + 4'(n), w);
    end
  endtask

  task automatic do_go(input logic dec, input logic chn,
                       input logic [127:0] exp, input logic wr,
                       input logic [3:0] wa, input logic [31:0] wd);
    op_s0 = cm_starts;
    op_d0 = done_cnt;
    bus.go_i    = 1'b1;
    bus.dec_i   = dec;
    bus.chain_i = chn;
    if (wr) begin
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = wa;
      bus.wr_data_i = wd;
    end
    sb.push_back(exp);
    @(negedge clk);
    bus.go_i    = 1'b0;
    bus.wr_en_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (done_cnt != op_d0) break;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 128'(done_cnt != op_d0), ONE);
  endtask

  task automatic finish_op(input string tag);
    wait_done(tag);
    repeat (3) @(negedge clk);
    check({tag, "_core_starts"}, 128'(cm_starts - op_s0), ONE);
    check({tag, "_done_pulses"}, 128'(done_cnt - op_d0), ONE);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w3;
    tk[0] = FIPS_KEY; tp[0] = FIPS_PT;   tc[0] = FIPS_CT;
    tk[1] = K2;       tp[1] = P1 ^ IV;   tc[1] = C1;
    tk[2] = K2;       tp[2] = P2 ^ C1;   tc[2] = C2;
    bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.go_i = 1'b0; bus.dec_i = 1'b0; bus.chain_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",       128'(bus.busy_o),       ZERO);
    check("rst_out_valid",  128'(bus.out_valid_o),  ZERO);
    check("rst_done",       128'(bus.done_o),       ZERO);
    check("rst_err",        128'(bus.err_o),        ZERO);
    check("rst_core_start", 128'(bus.core_start_o), ZERO);
    check("rst_out_data",   bus.out_data_o,         ZERO);
    check("rst_core_key",   bus.core_key_o,         ZERO);
    rst = 1'b0;
    @(negedge clk);
    check("release_busy", 128'(bus.busy_o), ZERO);

    // ECB encrypt, FIPS-197 vector
    write_block(KEY_BASE, FIPS_KEY, 4);
    write_block(DATA_BASE, FIPS_PT, 4);
    check("core_key_direct", bus.core_key_o, FIPS_KEY);
    do_go(1'b0, 1'b0, FIPS_CT, 1'b0, 4'd0, 32'd0);
    finish_op("ecb_enc");

    // CBC encrypt two blocks; last P2 word written in the go cycle
    write_block(KEY_BASE, K2, 4);
    write_block(IV_BASE, IV, 4);
    write_block(DATA_BASE, P1, 4);
    do_go(1'b0, 1'b1, C1, 1'b0, 4'd0, 32'd0);
    finish_op("cbc_enc1");
    write_block(DATA_BASE, P2, 3);
    w3 = P2[31:0];
    do_go(1'b0, 1'b1, C2, 1'b1, DATA_BASE + 4'd3, w3);
    finish_op("cbc_enc2");

    // CBC decrypt from the same IV
    write_block(IV_BASE, IV, 4);
    write_block(DATA_BASE, C1, 4);
    do_go(1'b1, 1'b1, P1, 1'b0, 4'd0, 32'd0);
    finish_op("cbc_dec1");
    write_block(DATA_BASE, C2, 4);
    do_go(1'b1, 1'b1, P2, 1'b0, 4'd0, 32'd0);
    finish_op("cbc_dec2");

    // go and data writes while busy
    write_block(KEY_BASE, FIPS_KEY, 4);
    write_block(DATA_BASE, FIPS_PT, 4);
    check("err_before_busy_go", 128'(bus.err_o), ZERO);
    do_go(1'b0, 1'b0, FIPS_CT, 1'b0, 4'd0, 32'd0);
    bus.go_i = 1'b1; bus.dec_i = 1'b1; bus.chain_i = 1'b1;
    bus.wr_en_i = 1'b1; bus.wr_addr_i = DATA_BASE; bus.wr_data_i = 32'hdeadbeef;
    @(negedge clk);
    bus.wr_addr_i = DATA_BASE + 4'd3; bus.wr_data_i = 32'h0badf00d;
    @(negedge clk);
    bus.go_i = 1'b0; bus.wr_en_i = 1'b0; bus.dec_i = 1'b0; bus.chain_i = 1'b0;
    check("err_on_busy_go", 128'(bus.err_o), ONE);
    finish_op("busy_go");
    check("err_sticky", 128'(bus.err_o), ONE);
    do_go(1'b0, 1'b0, FIPS_CT, 1'b0, 4'd0, 32'd0);
    check("err_cleared_by_go", 128'(bus.err_o), ZERO);
    check("out_valid_dropped_by_go", 128'(bus.out_valid_o), ZERO);
    finish_op("after_busy");

    // core_ready_i held low at ISSUE
    ready_hold = 1'b1;
    do_go(1'b0, 1'b0, FIPS_CT, 1'b0, 4'd0, 32'd0);
    check("ready_low_busy", 128'(bus.busy_o), ONE);
    for (int i = 0; i < 5; i++) begin
      check("start_withheld", 128'(bus.core_start_o), ZERO);
      @(negedge clk);
    end
    #1 ready_hold = 1'b0;
    #1 check("start_on_ready", 128'(bus.core_start_o), ONE);
    finish_op("ready_stall");

    // Reset during WAIT_DONE
    do_go(1'b0, 1'b0, FIPS_CT, 1'b0, 4'd0, 32'd0);
    repeat (3) @(negedge clk);
    check("midop_busy", 128'(bus.busy_o), ONE);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    check("midrst_busy",      128'(bus.busy_o),      ZERO);
    check("midrst_out_valid", 128'(bus.out_valid_o), ZERO);
    check("midrst_out_data",  bus.out_data_o,        ZERO);
    check("midrst_core_key",  bus.core_key_o,        ZERO);
    check("midrst_core_data", bus.core_data_o,       ZERO);
    check("midrst_err",       128'(bus.err_o),       ZERO);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release_busy", 128'(bus.busy_o), ZERO);
    repeat (20) @(negedge clk);
    check("no_done_after_rst", 128'(done_cnt - op_d0), ZERO);
    check("scoreboard_empty", 128'(sb.size()), ZERO);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
